// File: rtl/simple_cpu_sequencer.sv
// Instruction sequencer for the register-file + 74181 ALU datapath.
// Takes one instruction per valid/ready handshake. It drives the operand,
// ALU and write-back controls, waits for the ALU ripple to settle, then
// captures the result and flags and writes the result back to the register file.
module simple_cpu_sequencer #(
    parameter int  DATA_WIDTH  = 16,
    parameter int  NUM_REGS    = 8,
    parameter int  ALU_WAIT    = 1,
    localparam int ADDR_WIDTH  = $clog2(NUM_REGS),
    localparam int INSTR_WIDTH = 9 + 3*ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   reg_write_enable,
    output logic [ADDR_WIDTH-1:0]  reg_read_addr1,
    output logic [ADDR_WIDTH-1:0]  reg_read_addr2,
    output logic [ADDR_WIDTH-1:0]  reg_write_addr,
    output logic [DATA_WIDTH-1:0]  reg_write_data,
    output logic                   alu_cin,
    output logic                   alu_mode,
    output logic [3:0]             alu_sel,
    output logic [DATA_WIDTH-1:0]  alu_b_imm,
    output logic                   alu_b_use_imm,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic                   alu_cout,
    output logic                   busy,
    output logic                   done,
    output logic                   carry_flag,
    output logic                   zero_flag
);

    localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

    localparam logic [1:0] K_RR  = 2'b00;
    localparam logic [1:0] K_RI  = 2'b01;
    localparam logic [1:0] K_LD  = 2'b10;

    typedef struct packed {
        logic [1:0]            kind;
        logic [3:0]            sel;
        logic                  mode;
        logic                  cin;
        logic                  use_c;
        logic [ADDR_WIDTH-1:0] rd;
        logic [ADDR_WIDTH-1:0] rs1;
        logic [ADDR_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0] imm;
    } instr_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WRITE, RETIRE} state_t;

    state_t        state, state_n;
    instr_t        ins;
    logic [CW-1:0] wait_cnt;
    logic          accept;
    logic          last_wait;

    assign ins       = instr_t'(instr);
    assign accept    = (state == IDLE) && instr_valid;
    assign last_wait = (wait_cnt == CW'(ALU_WAIT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state decode: ALU kinds issue, LOAD goes straight to write-back, NOP retires.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    case (ins.kind)
                        K_RR, K_RI: state_n = ISSUE;
                        K_LD:       state_n = WRITE;
                        default:    state_n = RETIRE;
                    endcase
                end
            end
            ISSUE:   if (last_wait) state_n = WRITE;
            WRITE:   state_n = RETIRE;
            RETIRE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs: status from the next state, controls latched at accept,
    // and the result and flags captured on the final ISSUE edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_ready      <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            reg_write_enable <= 1'b0;
            reg_read_addr1   <= '0;
            reg_read_addr2   <= '0;
            reg_write_addr   <= '0;
            reg_write_data   <= '0;
            alu_cin          <= 1'b0;
            alu_mode         <= 1'b0;
            alu_sel          <= '0;
            alu_b_imm        <= '0;
            alu_b_use_imm    <= 1'b0;
            carry_flag       <= 1'b0;
            zero_flag        <= 1'b0;
            wait_cnt         <= '0;
        end else begin
            instr_ready      <= (state_n == IDLE);
            busy             <= (state_n != IDLE);
            reg_write_enable <= (state_n == WRITE);
            done             <= (state_n == RETIRE);
            wait_cnt         <= (state == ISSUE) ? wait_cnt + CW'(1) : '0;

            if (accept) begin
                reg_write_addr <= ins.rd;
                if (ins.kind == K_RR || ins.kind == K_RI) begin
                    reg_read_addr1 <= ins.rs1;
                    reg_read_addr2 <= ins.rs2;
                    alu_sel        <= ins.sel;
                    alu_mode       <= ins.mode;
                    // Chained adds feed the previous raw carry-out straight back in.
                    alu_cin        <= ins.use_c ? carry_flag : ins.cin;
                    alu_b_use_imm  <= (ins.kind == K_RI);
                    alu_b_imm      <= (ins.kind == K_RI) ? ins.imm : '0;
                end
                if (ins.kind == K_LD) reg_write_data <= ins.imm;
            end

            if (state == ISSUE && last_wait) begin
                reg_write_data <= alu_result;
                carry_flag     <= alu_cout;
                zero_flag      <= (alu_result == '0);
            end
        end
    end

endmodule

// File: tb/tb_simple_cpu_sequencer.sv
// Bench for simple_cpu_sequencer: two instances (ALU_WAIT=1 and 3), each with
// its own register file and 74181-style ALU. A reference model tracks the
// architectural registers and flags.
module tb_simple_cpu_sequencer;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int IW = 9 + 3*AW + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [1:0]          rst, valid, ready, we, cin, mode, uimm, cout, busy, done, cf, zf;
    logic [IW-1:0]       instr;
    logic [1:0][AW-1:0]  ra1, ra2, wa;
    logic [1:0][DW-1:0]  wd, bimm, res;
    logic [1:0][3:0]     sel;
    logic [DW-1:0]       rf   [2][8] = '{default: '0};
    logic [DW-1:0]       mreg [2][8] = '{default: '0};
    logic                mc [2] = '{default: 1'b0};
    logic                mz [2] = '{default: 1'b0};

    for (genvar g = 0; g < 2; g++) begin : g_dut
        simple_cpu_sequencer #(.DATA_WIDTH(DW), .NUM_REGS(8), .ALU_WAIT(g == 0 ? 1 : 3)) dut (
            .clk(clk), .reset(rst[g]), .instr_valid(valid[g]), .instr_ready(ready[g]),
            .instr(instr), .reg_write_enable(we[g]), .reg_read_addr1(ra1[g]),
            .reg_read_addr2(ra2[g]), .reg_write_addr(wa[g]), .reg_write_data(wd[g]),
            .alu_cin(cin[g]), .alu_mode(mode[g]), .alu_sel(sel[g]), .alu_b_imm(bimm[g]),
            .alu_b_use_imm(uimm[g]), .alu_result(res[g]), .alu_cout(cout[g]),
            .busy(busy[g]), .done(done[g]), .carry_flag(cf[g]), .zero_flag(zf[g]));
    end

    // 74181-style ALU, active-high data, carry-in adds one, carry-out = raw bit DW.
    function automatic logic [DW:0] alu(input logic [3:0] s, input logic m, input logic c,
                                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] f;
        if (m) begin
            case (s)
                4'b0000: f = ~a;        4'b0001: f = ~(a | b);
                4'b0010: f = ~a & b;    4'b0011: f = '0;
                4'b0100: f = ~(a & b);  4'b0101: f = ~b;
                4'b0110: f = a ^ b;     4'b0111: f = a & ~b;
                4'b1000: f = ~a | b;    4'b1001: f = ~(a ^ b);
                4'b1010: f = b;         4'b1011: f = a & b;
                4'b1100: f = '1;        4'b1101: f = a | ~b;
                4'b1110: f = a | b;     default: f = a;
            endcase
            return {1'b0, f};
        end
        if (s == 4'b1001) return {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
        if (s == 4'b0110) return {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, c};
        return {1'b0, a} + {{DW{1'b0}}, c};
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++)
            {cout[d], res[d]} = alu(sel[d], mode[d], cin[d], rf[d][ra1[d]],
                                    uimm[d] ? bimm[d] : rf[d][ra2[d]]);
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (we[d]) rf[d][wa[d]] <= wd[d];
    end

    function automatic logic [IW-1:0] mk(input logic [1:0] k, input logic [3:0] s, input logic m,
                                         input logic c, input logic uc, input logic [2:0] rd,
                                         input logic [2:0] r1, input logic [2:0] r2,
                                         input logic [15:0] imm);
        return {k, s, m, c, uc, rd, r1, r2, imm};
    endfunction

    // Offer one instruction (caller is at a negedge), follow it to retirement and
    // compare timing, controls, write-back and flags against the model.
    task automatic exec(input int d, input logic [IW-1:0] ins, input bit hold);
        logic [1:0] kind; logic [3:0] s; logic m, ci, uc, exp_cin;
        logic [2:0] rd, rs1, rs2; logic [DW-1:0] imm, a, b, exp_res, exp_bimm;
        logic [DW:0] r;
        int w, exp_we, exp_done, exp_rdy, exp_wn, we_n, we_k, done_n, done_k, rdy_k, n;
        bit issue_ok, busy_ok, wr_ok, is_alu;
        kind = ins[33:32]; s = ins[31:28]; m = ins[27]; ci = ins[26]; uc = ins[25];
        rd = ins[24:22]; rs1 = ins[21:19]; rs2 = ins[18:16]; imm = ins[15:0];
        w = (d == 0) ? 1 : 3;
        is_alu = (kind[1] == 1'b0);
        exp_cin = uc ? mc[d] : ci;
        a = mreg[d][rs1];
        b = (kind == 2'b01) ? imm : mreg[d][rs2];
        r = alu(s, m, exp_cin, a, b);
        exp_bimm = (kind == 2'b01) ? imm : '0;
        case (kind)
            2'b00, 2'b01: begin exp_we = w;  exp_done = w + 1; exp_res = r[DW-1:0]; exp_wn = 1; end
            2'b10:        begin exp_we = 0;  exp_done = 1;     exp_res = imm;       exp_wn = 1; end
            default:      begin exp_we = -1; exp_done = 0;     exp_res = '0;        exp_wn = 0; end
        endcase
        exp_rdy = exp_done + 1;

        instr = ins;
        valid[d] = 1'b1;
        n = 0;
        while (!ready[d] && n < 20) begin @(negedge clk); n++; end
        if (!ready[d]) begin
            tests++; fails++;
            $display("FAIL accept_timeout dut%0d: ready stayed %b, want 1", d, ready[d]);
            valid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        we_n = 0; we_k = -1; done_n = 0; done_k = -1; rdy_k = -1;
        issue_ok = 1; busy_ok = 1; wr_ok = 1;
        for (int k = 0; k < w + 6; k++) begin
            if (!hold) valid[d] = 1'b0;
            if (we[d]) begin
                we_n++; we_k = k;
                if (wa[d] !== rd || wd[d] !== exp_res) wr_ok = 0;
            end
            if (done[d]) begin done_n++; done_k = k; end
            if (ready[d]) begin rdy_k = k; break; end
            if (busy[d] !== 1'b1) busy_ok = 0;
            if (is_alu && k < w)
                if (ra1[d] !== rs1 || ra2[d] !== rs2 || sel[d] !== s || mode[d] !== m ||
                    cin[d] !== exp_cin || uimm[d] !== (kind == 2'b01) || bimm[d] !== exp_bimm)
                    issue_ok = 0;
            @(negedge clk);
        end

        tests++;
        if (we_n !== exp_wn) begin fails++;
            $display("FAIL we_count dut%0d ins=%h: got %0d want %0d", d, ins, we_n, exp_wn); end
        if (exp_wn == 1) begin
            tests++;
            if (we_k !== exp_we) begin fails++;
                $display("FAIL we_time dut%0d ins=%h: got %0d want %0d", d, ins, we_k, exp_we); end
            tests++;
            if (!wr_ok) begin fails++;
                $display("FAIL write_port dut%0d ins=%h: got a=%0d d=%h want a=%0d d=%h",
                         d, ins, wa[d], wd[d], rd, exp_res); end
        end
        tests++;
        if (done_n !== 1 || done_k !== exp_done) begin fails++;
            $display("FAIL done_pulse dut%0d ins=%h: got n=%0d k=%0d want n=1 k=%0d",
                     d, ins, done_n, done_k, exp_done); end
        tests++;
        if (rdy_k !== exp_rdy) begin fails++;
            $display("FAIL ready_time dut%0d ins=%h: got %0d want %0d", d, ins, rdy_k, exp_rdy); end
        tests++;
        if (!busy_ok) begin fails++;
            $display("FAIL busy dut%0d ins=%h: got 0 while in flight, want 1", d, ins); end
        if (is_alu) begin
            tests++;
            if (!issue_ok) begin fails++;
                $display("FAIL issue_ctrl dut%0d ins=%h: got sel=%h m=%b c=%b ui=%b imm=%h want sel=%h m=%b c=%b ui=%b imm=%h",
                         d, ins, sel[d], mode[d], cin[d], uimm[d], bimm[d], s, m, exp_cin,
                         kind == 2'b01, exp_bimm); end
        end

        if (is_alu) begin
            mreg[d][rd] = r[DW-1:0]; mc[d] = r[DW]; mz[d] = (r[DW-1:0] == '0);
        end else if (kind == 2'b10) begin
            mreg[d][rd] = imm;
        end
        tests++;
        if (rf[d][rd] !== mreg[d][rd]) begin fails++;
            $display("FAIL regfile dut%0d r%0d: got %h want %h", d, rd, rf[d][rd], mreg[d][rd]); end
        tests++;
        if (cf[d] !== mc[d] || zf[d] !== mz[d]) begin fails++;
            $display("FAIL flags dut%0d ins=%h: got c=%b z=%b want c=%b z=%b",
                     d, ins, cf[d], zf[d], mc[d], mz[d]); end
    endtask

    task automatic test_reset();
        rst = 2'b11; valid = 2'b00; instr = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({ready[d], busy[d], done[d], we[d], cf[d], zf[d], cin[d], mode[d], uimm[d]} !== 9'b1_0000_0000 ||
                sel[d] !== '0 || ra1[d] !== '0 || ra2[d] !== '0 || wa[d] !== '0 ||
                wd[d] !== '0 || bimm[d] !== '0) begin
                fails++;
                $display("FAIL reset_state dut%0d: got rdy=%b busy=%b done=%b we=%b cf=%b zf=%b wd=%h want rdy=1 rest 0",
                         d, ready[d], busy[d], done[d], we[d], cf[d], zf[d], wd[d]);
            end
        end
        rst = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_add_chain();
        exec(0, mk(2'b10, 4'h0, 0, 0, 0, 3'd2, 3'd0, 3'd0, 16'h1234), 0);
        exec(0, mk(2'b10, 4'h0, 0, 0, 0, 3'd3, 3'd0, 3'd0, 16'h5678), 0);
        exec(0, mk(2'b00, 4'b1001, 0, 0, 0, 3'd4, 3'd2, 3'd3, 16'h0000), 0);
        tests++;
        if (rf[0][4] !== 16'h68AC || cf[0] !== 1'b0) begin fails++;
            $display("FAIL add_rr: got r4=%h c=%b want r4=68ac c=0", rf[0][4], cf[0]); end
        exec(0, mk(2'b10, 4'h0, 0, 0, 0, 3'd5, 3'd0, 3'd0, 16'hFFFF), 0);
        exec(0, mk(2'b01, 4'b1001, 0, 0, 0, 3'd5, 3'd5, 3'd0, 16'h0001), 0);
        tests++;
        if (rf[0][5] !== 16'h0000 || cf[0] !== 1'b1 || zf[0] !== 1'b1) begin fails++;
            $display("FAIL add_wrap: got r5=%h c=%b z=%b want r5=0000 c=1 z=1", rf[0][5], cf[0], zf[0]); end
        exec(0, mk(2'b01, 4'b1001, 0, 0, 1, 3'd6, 3'd5, 3'd0, 16'h0000), 0);
        tests++;
        if (rf[0][6] !== 16'h0001) begin fails++;
            $display("FAIL add_use_c: got r6=%h want 0001", rf[0][6]); end
    endtask

    task automatic test_logic_imm();
        exec(0, mk(2'b01, 4'b1011, 1, 0, 0, 3'd7, 3'd2, 3'd0, 16'h00FF), 0);
        tests++;
        if (rf[0][7] !== 16'h0034) begin fails++;
            $display("FAIL and_imm: got r7=%h want 0034", rf[0][7]); end
        exec(0, mk(2'b01, 4'b1110, 1, 0, 0, 3'd7, 3'd7, 3'd0, 16'hFF00), 0);
        tests++;
        if (rf[0][7] !== 16'hFF34) begin fails++;
            $display("FAIL or_imm: got r7=%h want ff34", rf[0][7]); end
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            exec(d, mk(2'b10, 4'h0, 0, 0, 0, 3'd1, 3'd0, 3'd0, 16'h4321), 1);
            exec(d, mk(2'b00, 4'b1001, 0, 1, 0, 3'd1, 3'd1, 3'd1, 16'h0000), 1);
            exec(d, mk(2'b01, 4'b0110, 1, 0, 0, 3'd2, 3'd1, 3'd0, 16'hA5A5), 0);
        end
    endtask

    task automatic test_nop_load();
        exec(0, mk(2'b10, 4'h0, 0, 0, 0, 3'd3, 3'd0, 3'd0, 16'h8000), 0);
        exec(0, mk(2'b00, 4'b1001, 0, 0, 0, 3'd3, 3'd3, 3'd3, 16'h0000), 0);
        exec(0, mk(2'b11, 4'hF, 1, 1, 1, 3'd3, 3'd3, 3'd3, 16'hFFFF), 0);
        exec(0, mk(2'b10, 4'h0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 16'h0042), 0);
        tests++;
        if (cf[0] !== 1'b1 || zf[0] !== 1'b1 || rf[0][3] !== 16'h0000) begin fails++;
            $display("FAIL load_keeps_flags: got c=%b z=%b r3=%h want c=1 z=1 r3=0000", cf[0], zf[0], rf[0][3]); end
    endtask

    task automatic test_random();
        logic [1:0] k; logic m; logic [3:0] s; logic [15:0] imm;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                k = 2'($urandom_range(0, 3));
                m = 1'($urandom_range(0, 1));
                s = m ? 4'($urandom) : ($urandom_range(0, 1) ? 4'b1001 : 4'b0110);
                case ($urandom_range(0, 3))
                    0:       imm = 16'h0000;
                    1:       imm = 16'hFFFF;
                    default: imm = 16'($urandom);
                endcase
                exec(d, mk(k, s, m, 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                           3'($urandom), imm), 1'($urandom));
            end
            valid[d] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] old;
        bit seen;
        int n;
        exec(1, mk(2'b10, 4'h0, 0, 0, 0, 3'd7, 3'd0, 3'd0, 16'hFFFF), 0);
        exec(1, mk(2'b01, 4'b1001, 0, 1, 0, 3'd6, 3'd7, 3'd0, 16'h0000), 0);
        tests++;
        if (cf[1] !== 1'b1) begin fails++;
            $display("FAIL pre_reset_carry: got %b want 1", cf[1]); end
        old = mreg[1][4];
        instr = mk(2'b00, 4'b1001, 0, 0, 0, 3'd4, 3'd7, 3'd7, 16'h0000);
        valid[1] = 1'b1;
        n = 0;
        while (!ready[1] && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        valid[1] = 1'b0;
        seen = we[1] | done[1];
        @(negedge clk);
        seen |= we[1] | done[1];
        rst[1] = 1'b1;
        repeat (2) begin @(negedge clk); seen |= we[1] | done[1]; end
        rst[1] = 1'b0;
        repeat (6) begin @(negedge clk); seen |= we[1] | done[1]; end
        mc[1] = 1'b0; mz[1] = 1'b0;
        tests++;
        if (seen !== 1'b0) begin fails++;
            $display("FAIL abort_quiet: got we/done activity=%b want 0", seen); end
        tests++;
        if (ready[1] !== 1'b1 || busy[1] !== 1'b0 || cf[1] !== 1'b0 || zf[1] !== 1'b0) begin fails++;
            $display("FAIL after_abort: got rdy=%b busy=%b c=%b z=%b want 1 0 0 0", ready[1], busy[1], cf[1], zf[1]); end
        tests++;
        if (rf[1][4] !== old) begin fails++;
            $display("FAIL abort_r4: got %h want %h", rf[1][4], old); end
        exec(1, mk(2'b10, 4'h0, 0, 0, 0, 3'd4, 3'd0, 3'd0, 16'h0BEE), 0);
    endtask

    initial begin
        test_reset();
        test_add_chain();
        test_logic_imm();
        test_back_to_back();
        test_nop_load();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "watchdog");
    end
endmodule
